// File: rtl/pll_rst_ctrl.sv
// PLL lock supervisor: synchronizes EHXPLLL LOCK, pulses the PLL reset on lock timeout and
// releases the SoC reset after a stable-lock window. Optional loss counter: PLL_RST_CTRL_LOSS_CNT_EN.
module pll_rst_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             sys_ready,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] loss_count,
  input  logic             loss_clear
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_PRST   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  localparam int TMAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int TMAX_B = (HOLD_CYCLES > PLL_RST_CYCLES) ? HOLD_CYCLES : PLL_RST_CYCLES;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_PRST   = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_STABLE = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD   = TW'(HOLD_CYCLES - 1);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_locked_s;
  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [TW-1:0]          r_timer;
  logic                   r_sys_reset;
  logic                   r_sys_ready;
  logic                   r_pll_rst;
  logic                   w_sys_reset_d;
  logic                   w_sys_ready_d;
  logic                   w_pll_rst_d;

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) r_rst_sync <= 2'b00;
    else                  r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // The lock synchronizer runs on the raw reset so it is already filled when the FSM leaves reset.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync[0] <= pll_locked;
      for (int i = 1; i < SYNC_STAGES; i++) r_lock_sync[i] <= r_lock_sync[i-1];
    end
  end
  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];

  always_ff @(posedge io_mainClk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_WAIT;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_timer <= '0;
      else if (r_timer != '1) r_timer <= r_timer + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (w_locked_s)             w_next = S_STABLE;
        else if (r_timer == T_LOCK) w_next = S_PRST;
      end
      S_PRST: begin
        if (r_timer == T_PRST) w_next = S_WAIT;
      end
      S_STABLE: begin
        if (!w_locked_s)              w_next = S_WAIT;
        else if (r_timer == T_STABLE) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!w_locked_s)            w_next = S_WAIT;
        else if (r_timer == T_HOLD) w_next = S_RUN;
      end
      S_RUN: begin
        if (!w_locked_s) w_next = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

  always_comb begin
    w_sys_reset_d = (w_next != S_RUN);
    w_sys_ready_d = (w_next == S_RUN);
    w_pll_rst_d   = (w_next == S_PRST);
  end

  always_ff @(posedge io_mainClk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sys_reset <= 1'b1;
      r_sys_ready <= 1'b0;
      r_pll_rst   <= 1'b0;
    end else begin
      r_sys_reset <= w_sys_reset_d;
      r_sys_ready <= w_sys_ready_d;
      r_pll_rst   <= w_pll_rst_d;
    end
  end

  assign sys_reset = r_sys_reset;
  assign sys_ready = r_sys_ready;
  assign pll_rst   = r_pll_rst;
  assign state     = r_state;

`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  logic [CNT_W-1:0] r_loss_count;
  logic             w_loss_evt;

  assign w_loss_evt = (r_state == S_RUN) && (w_next == S_WAIT);

  // A clear coinciding with a loss still records that loss.
  always_ff @(posedge io_mainClk or negedge w_rst_n) begin
    if (!w_rst_n)                    r_loss_count <= '0;
    else if (loss_clear)             r_loss_count <= w_loss_evt ? CNT_W'(1) : '0;
    else if (w_loss_evt && r_loss_count != '1) r_loss_count <= r_loss_count + 1'b1;
  end
  assign loss_count = r_loss_count;
`else
  logic w_unused_loss_clear;
  assign w_unused_loss_clear = loss_clear;
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl: vector table of lock-input segments plus
// hand-written sequences for async reset mid-pulse and loss-counter saturation.
module tb_pll_rst_ctrl;

  localparam int SYNC_STAGES    = 2;
  localparam int STABLE_CYCLES  = 8;
  localparam int HOLD_CYCLES    = 4;
  localparam int LOCK_TIMEOUT   = 20;
  localparam int PLL_RST_CYCLES = 3;
  localparam int CNT_W          = 8;

`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             locked;
  logic             clear;
  logic             pll_rst;
  logic             sys_reset;
  logic             sys_ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] loss_count;

  typedef struct {
    logic       locked;
    logic       clear;
    int         ncyc;
    logic [2:0] st;
    logic       rst;
    logic       rdy;
    logic       prst;
    logic [7:0] loss;
  } vec_t;

  vec_t        vecs[19];
  logic [13:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  pll_rst_ctrl #(
    .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .PLL_RST_CYCLES(PLL_RST_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .io_mainClk(clk),
    .io_asyncReset_n(rst_n),
    .pll_locked(locked),
    .pll_rst(pll_rst),
    .sys_reset(sys_reset),
    .sys_ready(sys_ready),
    .state(state),
    .loss_count(loss_count),
    .loss_clear(clear)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [2:0] st, input logic rst, input logic rdy,
                          input logic prst, input logic [7:0] loss);
    exp_q.push_back({st, rst, rdy, prst, (LOSS_EN ? loss : 8'd0)});
  endtask

  task automatic check(input string name);
    logic [13:0] act;
    logic [13:0] exp;
    act = {state, sys_reset, sys_ready, pll_rst, loss_count};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got st=%0d rst=%b rdy=%b prst=%b loss=%0d",
               name, act[13:11], act[10], act[9], act[8], act[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got st=%0d rst=%b rdy=%b prst=%b loss=%0d, want st=%0d rst=%b rdy=%b prst=%b loss=%0d",
                 name, act[13:11], act[10], act[9], act[8], act[7:0],
                 exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k;
    k = 0;
    while (!sys_ready && k < budget) begin
      step(1);
      k++;
    end
    n_vec++;
    if (sys_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: sys_ready=%b after %0d cycles, want 1", name, sys_ready, budget);
    end
  endtask

  initial begin
    // locked, clear, cycles -> state, sys_reset, sys_ready, pll_rst, loss_count (macro build)
    vecs[0]  = '{1'b1, 1'b0, 14, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0,  1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 10, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0,  2, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0,  1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 19, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b0, 1'b0,  1, 3'd1, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 1'b0,  2, 3'd1, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 1'b0,  1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 19, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b0,  1, 3'd1, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 1'b0,  3, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[12] = '{1'b1, 1'b0,  5, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{1'b0, 1'b0,  3, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[14] = '{1'b1, 1'b0, 14, 3'd3, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[15] = '{1'b1, 1'b0,  1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[16] = '{1'b0, 1'b1,  3, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[17] = '{1'b0, 1'b1,  1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[18] = '{1'b0, 1'b0,  2, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0};

    rst_n  = 1'b0;
    locked = 1'b0;
    clear  = 1'b0;
    step(3);
    push_exp(3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("reset_state");

    // Lock present from the moment reset releases; first sampling edge is the next posedge.
    locked = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 19; i++) begin
      locked = vecs[i].locked;
      clear  = vecs[i].clear;
      push_exp(vecs[i].st, vecs[i].rst, vecs[i].rdy, vecs[i].prst, vecs[i].loss);
      step(vecs[i].ncyc);
      check($sformatf("vec%0d", i));
    end
    clear = 1'b0;

    // Async reset in the middle of a PLL reset pulse.
    begin
      int k;
      k = 0;
      while (!pll_rst && k < 40) begin
        step(1);
        k++;
      end
      n_vec++;
      if (pll_rst !== 1'b1) begin
        n_err++;
        $display("FAIL wait_pll_rst: pll_rst=%b after 40 cycles, want 1", pll_rst);
      end
    end
    step(1);
    #2 rst_n = 1'b0;
    #1;
    push_exp(3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("async_rst_mid_prst");
    step(2);
    rst_n = 1'b1;
    step(21);
    push_exp(3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("timeout_restart_pre");
    step(1);
    push_exp(3'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    check("timeout_restart_prst");
    step(2);
    push_exp(3'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    check("prst_width_hold");
    step(1);
    push_exp(3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("prst_width_end");

    // Repeated lock losses drive the counter into saturation.
    locked = 1'b1;
    wait_ready("first_run", 60);
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      step(3);
      if (i == 0) begin
        push_exp(3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
        check("first_loss");
      end
      if (i == 255) begin
        push_exp(3'd0, 1'b1, 1'b0, 1'b0, 8'd255);
        check("loss_256th");
      end
      locked = 1'b1;
      step(15);
    end
    push_exp(3'd4, 1'b0, 1'b1, 1'b0, 8'd255);
    check("loss_saturated");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_rst_ctrl.md
PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SYNC_STAGES, 2: flops in the pll_locked synchronizer.
- STABLE_CYCLES, 1024: cycles pll_locked must stay high before the hold phase.
- HOLD_CYCLES, 16: extra cycles sys_reset stays asserted after stability.
- LOCK_TIMEOUT, 65536: cycles in WAIT_LOCK before the PLL is reset.
- PLL_RST_CYCLES, 32: width of the pll_rst pulse.
- CNT_W, 8: width of loss_count.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- io_mainClk, in, 1: free-running 25 MHz board clock; the only clock.
- io_asyncReset_n, in, 1: asynchronous, active-low reset.
- pll_locked, in, 1: EHXPLLL LOCK; asynchronous to io_mainClk.
- pll_rst, out, 1: drives EHXPLLL RST; active high.
- sys_reset, out, 1: active-high SoC reset request.
- sys_ready, out, 1: high while in RUN.
- state, out, 3: current FSM state encoding.
- loss_count, out, CNT_W: saturating count of lock-loss events seen in RUN.
- loss_clear, in, 1: synchronous clear of loss_count.

Function
REQ-003 pll_locked SHALL pass through a SYNC_STAGES-flop synchronizer, giving locked_s; no other logic SHALL use pll_locked directly.
REQ-004 The FSM SHALL have states WAIT_LOCK=0, PLL_RST=1, STABLE=2, HOLD=3, RUN=4; codes 5-7 SHALL go to WAIT_LOCK.
REQ-005 WAIT_LOCK behaviour:
- timer increments each cycle.
- locked_s=1 -> STABLE, timer cleared.
- Otherwise, timer==LOCK_TIMEOUT-1 -> PLL_RST, timer cleared.
REQ-006 PLL_RST SHALL hold pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK; locked_s SHALL be ignored during PLL_RST.
REQ-007 STABLE behaviour:
- locked_s=0 -> WAIT_LOCK (glitch restart).
- timer==STABLE_CYCLES-1 -> HOLD.
REQ-008 HOLD behaviour:
- locked_s=0 -> WAIT_LOCK.
- timer==HOLD_CYCLES-1 -> RUN.
REQ-009 RUN SHALL persist while locked_s=1; locked_s=0 -> WAIT_LOCK.
REQ-010 The timer SHALL be cleared on every state change, so each entry to WAIT_LOCK restarts the full timeout.
REQ-011 All outputs SHALL be registered and decoded from next-state:
- sys_reset = (next!=RUN).
- sys_ready = (next==RUN).
- pll_rst = (next==PLL_RST).
REQ-012 sys_reset SHALL fall exactly SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES+1 rising edges after the first edge that samples pll_locked=1, provided the lock holds.
REQ-013 sys_reset SHALL rise SYNC_STAGES+1 edges after the first edge that samples pll_locked=0 in RUN.
REQ-014 The timer SHALL be wide enough for the largest of LOCK_TIMEOUT, STABLE_CYCLES, HOLD_CYCLES and PLL_RST_CYCLES, and SHALL never wrap.

Reset
REQ-015 io_asyncReset_n low SHALL asynchronously set:
- state=WAIT_LOCK, timer=0, synchronizer=0.
- sys_reset=1, sys_ready=0, pll_rst=0, loss_count=0.
REQ-016 Release of io_asyncReset_n SHALL pass through an internal 2-flop reset synchronizer: assertion is asynchronous, deassertion is synchronous to io_mainClk.
REQ-017 Reset asserted in any state, including mid-PLL_RST, SHALL drop pll_rst immediately and restart from WAIT_LOCK.

Configuration
REQ-018 With PLL_RST_CTRL_LOSS_CNT_EN defined:
- each RUN->WAIT_LOCK transition SHALL increment loss_count, saturating at all-ones.
- loss_clear=1 SHALL zero it.
- loss_clear and a loss event in the same cycle SHALL yield 1.
REQ-019 Without PLL_RST_CTRL_LOSS_CNT_EN, loss_count SHALL be constant 0, loss_clear SHALL be ignored, and no counter logic SHALL be built.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOCK_TIMEOUT=20, PLL_RST_CYCLES=3)
REQ-020 Release reset, pll_locked=1 from then on -> sys_reset falls after exactly 15 edges; sys_ready=1; state=4.
REQ-021 pll_locked held 0 -> pll_rst high for 3 cycles after 20 cycles in WAIT_LOCK; pattern repeats every 23 cycles.
REQ-022 pll_locked pulses low for 3 cycles during STABLE -> FSM returns to WAIT_LOCK; sys_reset stays 1; full 15-edge count restarts after the lock returns.
REQ-023 In RUN, drop pll_locked -> sys_reset=1 after 3 edges; with the macro, loss_count goes 0->1; 300 drops with CNT_W=8 saturate at 255.
REQ-024 loss_clear coincident with a loss event -> loss_count=1; io_asyncReset_n pulsed mid-PLL_RST -> pll_rst=0 immediately and state=0.
